// File: rtl/spiker_seq_pkg.sv
// spiker_seq_pkg: shared types and default sizing for the spiker step sequencer.
package spiker_seq_pkg;
    localparam int DEF_N_BEATS     = 200;
    localparam int DEF_STEP_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {IDLE, START, FEED, WAIT_DONE, NEXT, FINISH} state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2
    } err_t;
endpackage

// File: rtl/spiker_seq_wdog.sv
// spiker_seq_wdog: saturating cycle counter that flags when the core has taken too long.
module spiker_seq_wdog
    import spiker_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = en_i && cnt_q == CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && !expired_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/spiker_sequencer.sv
// spiker_sequencer: runs n timesteps of start / beat feed / wait-for-done against the spiker core.
module spiker_sequencer
    import spiker_seq_pkg::*;
#(
    parameter int N_BEATS     = DEF_N_BEATS,
    parameter int STEP_W      = DEF_STEP_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic              go_i,
    input  logic              abort_i,
    input  logic [STEP_W-1:0] n_steps_i,
    output logic              core_start_o,
    output logic              core_sample_o,
    input  logic              core_ready_i,
    input  logic              core_done_i,
    output logic              busy_o,
    output logic [STEP_W-1:0] step_idx_o,
    output logic              done_o,
    output logic              irq_o,
    input  logic              irq_clr_i,
    output logic [1:0]        err_o
);
    localparam int BW = $clog2(N_BEATS + 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] n_q, idx_q;
    logic [BW-1:0]     beat_q;
    err_t              err_q;
    logic              irq_q, zdone_q;
    logic              go_zero, go_run, xfer, last_beat, last_step;
    logic              expired, abort, to_evt, irq_set;
    logic              unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign go_zero   = go_i && state_q == IDLE && n_steps_i == '0;
    assign go_run    = go_i && state_q == IDLE && n_steps_i != '0;
    assign abort     = abort_i && state_q != IDLE;
    assign xfer      = state_q == FEED && core_ready_i;
    assign last_beat = beat_q == BW'(N_BEATS - 1);
    assign last_step = idx_q == n_q - 1'b1;
    assign to_evt    = state_q == WAIT_DONE && !core_done_i && expired && !abort;
    // FINISH sets irq on entry and again while present, so a clear landing on FINISH loses.
    assign irq_set   = go_zero || state_d == FINISH || state_q == FINISH || to_evt || abort;

    spiker_seq_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_q != WAIT_DONE),
        .en_i     (state_q == WAIT_DONE),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (go_run) state_d = START;
            START:     state_d = FEED;
            FEED:      if (xfer && last_beat) state_d = WAIT_DONE;
            WAIT_DONE: if (core_done_i) state_d = NEXT;
                       else if (expired) state_d = IDLE;
            NEXT:      state_d = last_step ? FINISH : START;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        core_start_o  = state_q == START;
        core_sample_o = state_q == FEED;
        busy_o        = state_q != IDLE;
        done_o        = state_q == FINISH || zdone_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q     <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            err_q   <= ERR_NONE;
            irq_q   <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            irq_q   <= irq_set || (irq_q && !irq_clr_i);
            zdone_q <= go_zero;
            if (go_run) begin
                n_q   <= n_steps_i;
                idx_q <= '0;
                err_q <= ERR_NONE;
            end else if (state_q == NEXT && !last_step && !abort) begin
                idx_q <= idx_q + 1'b1;
            end
            if (abort) err_q <= ERR_ABORT;
            else if (to_evt) err_q <= ERR_TIMEOUT;
            if (state_q == START) beat_q <= '0;
            else if (xfer) beat_q <= beat_q + 1'b1;
        end
    end

    assign irq_o      = irq_q;
    assign err_o      = err_q;
    assign step_idx_o = idx_q;
endmodule

// File: tb/tb_spiker_sequencer.sv
// tb_spiker_sequencer: plays the spiker core against the sequencer and checks run timing/status.
module tb_spiker_sequencer;
    localparam int NB = 200;
    localparam int SW = 16;
    localparam int TO = 16;

    typedef struct {
        int n;
        int mode;
        int d;
        int fin;
        int beats;
    } vec_t;

    logic          clk_i = 1'b0, rst_ni = 1'b0, test_mode_i = 1'b0;
    logic          go_i = 1'b0, abort_i = 1'b0, core_ready_i = 1'b0, core_done_i = 1'b0, irq_clr_i = 1'b0;
    logic [SW-1:0] n_steps_i = '0;
    logic [SW-1:0] step_idx_o;
    logic          core_start_o, core_sample_o, busy_o, done_o, irq_o;
    logic [1:0]    err_o;

    int total = 0;
    int bad = 0;
    bit rdy[8192];
    int dl[64];

    always #5 clk_i = ~clk_i;

    spiker_sequencer #(.N_BEATS(NB), .STEP_W(SW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .go_i(go_i), .abort_i(abort_i),
        .n_steps_i(n_steps_i), .core_start_o(core_start_o), .core_sample_o(core_sample_o),
        .core_ready_i(core_ready_i), .core_done_i(core_done_i), .busy_o(busy_o),
        .step_idx_o(step_idx_o), .done_o(done_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i), .err_o(err_o)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Cycle 0 carries go; START is cycle 1. Each step: start, feed until the NB-th ready beat,
    // wait (done arrives d cycles after WAIT_DONE entry), NEXT; FINISH follows the last NEXT.
    function automatic int model_finish(input int n);
        int t = 1;
        int c;
        for (int s = 0; s < n; s++) begin
            int k = 0;
            c = t;
            while (k < NB) begin
                c++;
                if (rdy[c]) k++;
            end
            t = c + dl[s] + 3;
        end
        return t;
    endfunction

    task automatic fill(input int mode, input int dfix, input bit rnd);
        for (int c = 0; c < 8192; c++)
            rdy[c] = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : (($urandom % 4) != 0);
        for (int s = 0; s < 64; s++) dl[s] = rnd ? int'($urandom_range(0, 12)) : dfix;
    endtask

    task automatic clr_irq();
        @(negedge clk_i);
        irq_clr_i = 1'b1;
        @(negedge clk_i);
        irq_clr_i = 1'b0;
        chk("irq_clear", irq_o, 0);
    endtask

    task automatic run(input int n, input bit nodone, input int abort_step, input int clr_at,
                       input int limit, input int tail, output int done_c, output int idle_c,
                       output int beats, output int starts, output int abort_c);
        int sb = 0;
        int stp = 0;
        int done_at = -1;
        done_c = -1; idle_c = -1; beats = 0; starts = 0; abort_c = -1;
        @(negedge clk_i);
        go_i = 1'b1;
        n_steps_i = SW'(n);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk_i);
            if (core_start_o) begin
                chk("start_idx", step_idx_o, starts);
                starts++;
            end
            if (core_sample_o && rdy[c]) begin
                beats++;
                sb++;
                if (sb == NB) begin
                    sb = 0;
                    done_at = c + 1 + dl[stp];
                    stp++;
                end
            end
            if (done_o && done_c < 0) done_c = c;
            if (!busy_o && idle_c < 0) idle_c = c;
            go_i = (c == 30);
            n_steps_i = SW'(7);
            core_ready_i = rdy[c];
            core_done_i = !nodone && c == done_at;
            abort_i = 1'b0;
            if (abort_step == starts && core_sample_o && sb == 50 && abort_c < 0) begin
                abort_i = 1'b1;
                abort_c = c;
            end
            irq_clr_i = (c == clr_at);
            if (idle_c >= 0 && c >= idle_c + tail) break;
        end
        go_i = 1'b0; core_ready_i = 1'b0; core_done_i = 1'b0; abort_i = 1'b0; irq_clr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t tbl[3];
        int done_c, idle_c, beats, starts, abort_c, n, exp;
        tbl[0] = '{1, 0, 0, 204, 200};
        tbl[1] = '{2, 1, 0, 805, 400};
        tbl[2] = '{3, 0, 2, 616, 600};

        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_start", core_start_o, 0);
        chk("rst_sample", core_sample_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_idx", step_idx_o, 0);
        rst_ni = 1'b1;

        for (int i = 0; i < 3; i++) begin
            fill(tbl[i].mode, tbl[i].d, 1'b0);
            clr_irq();
            run(tbl[i].n, 1'b0, -1, tbl[i].fin, 4000, 2, done_c, idle_c, beats, starts, abort_c);
            chk("vec_done_cycle", done_c, tbl[i].fin);
            chk("vec_beats", beats, tbl[i].beats);
            chk("vec_starts", starts, tbl[i].n);
            chk("vec_idle", idle_c, tbl[i].fin + 1);
            chk("vec_last_idx", step_idx_o, tbl[i].n - 1);
            chk("vec_irq_kept", irq_o, 1);
            chk("vec_err", err_o, 0);
        end

        repeat (4) begin
            n = $urandom_range(1, 3);
            fill(2, 0, 1'b1);
            exp = model_finish(n);
            clr_irq();
            run(n, 1'b0, -1, -1, 6000, 2, done_c, idle_c, beats, starts, abort_c);
            chk("rnd_done_cycle", done_c, exp);
            chk("rnd_beats", beats, n * NB);
            chk("rnd_starts", starts, n);
            chk("rnd_irq", irq_o, 1);
            chk("rnd_err", err_o, 0);
        end

        fill(0, 0, 1'b0);
        clr_irq();
        run(1, 1'b1, -1, -1, 1000, 2, done_c, idle_c, beats, starts, abort_c);
        chk("to_idle_cycle", idle_c, 202 + TO);
        chk("to_no_done", done_c, -1);
        chk("to_beats", beats, NB);
        chk("to_err", err_o, 1);
        chk("to_irq", irq_o, 1);
        chk("to_busy", busy_o, 0);

        fill(0, 0, 1'b0);
        clr_irq();
        run(5, 1'b0, 3, -1, 3000, 300, done_c, idle_c, beats, starts, abort_c);
        chk("ab_cycle", abort_c, 1 + 2 * (NB + 3) + 50);
        chk("ab_idle", idle_c, abort_c + 1);
        chk("ab_starts", starts, 3);
        chk("ab_no_done", done_c, -1);
        chk("ab_err", err_o, 2);
        chk("ab_irq", irq_o, 1);

        clr_irq();
        @(negedge clk_i);
        go_i = 1'b1;
        n_steps_i = '0;
        @(negedge clk_i);
        go_i = 1'b0;
        chk("z_done", done_o, 1);
        chk("z_irq", irq_o, 1);
        chk("z_busy", busy_o, 0);
        chk("z_start", core_start_o, 0);
        @(negedge clk_i);
        chk("z_done_pulse", done_o, 0);
        chk("z_start2", core_start_o, 0);

        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("idle_abort_busy", busy_o, 0);
        chk("idle_abort_err", err_o, 2);

        fill(0, 0, 1'b0);
        clr_irq();
        run(1, 1'b1, -1, -1, 205, 2, done_c, idle_c, beats, starts, abort_c);
        chk("mr_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mr_busy0", busy_o, 0);
        chk("mr_start0", core_start_o, 0);
        chk("mr_sample0", core_sample_o, 0);
        chk("mr_done0", done_o, 0);
        chk("mr_irq0", irq_o, 0);
        chk("mr_err0", err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        done_c = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o || irq_o || busy_o) done_c++;
        end
        chk("mr_silent", done_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spiker_sequencer.md
SPIKER_SEQUENCER -- requirements
Module: spiker_sequencer

Interface
REQ-001 Parameter N_BEATS, default 200: sample beats per timestep, i.e. 800-bit window / 4-bit shift.
REQ-002 Parameter STEP_W, default 16: width of the step count and step index.
REQ-003 Parameter TIMEOUT_CYC, default 4096: maximum cycles in WAIT_DONE.
REQ-004 Ports: clk_i  in  1  clock, rising edge.
REQ-005 Ports: rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 Ports: test_mode_i  in  1  DFT mode, functionally ignored.
REQ-007 Ports: go_i  in  1  one-cycle start pulse from the register file.
REQ-008 Ports: abort_i  in  1  level; cancels the run.
REQ-009 Ports: n_steps_i  in  STEP_W  timesteps per run.
REQ-010 Ports: core_start_o  out  1  one-cycle step-start pulse to the spiker core and reader.
REQ-011 Ports: core_sample_o / core_ready_i  out/in  1/1  beat valid/ready pair.
REQ-012 Ports: core_done_i  in  1  core finished current step.
REQ-013 Ports: busy_o  out  1  run in progress.
REQ-014 Ports: step_idx_o  out  STEP_W  current step.
REQ-015 Ports: done_o  out  1  one-cycle run-complete pulse.
REQ-016 Ports: irq_o  out  1  sticky interrupt; irq_clr_i  in  1  clears it.
REQ-017 Ports: err_o  out  2  sticky status: 0 none, 1 timeout, 2 abort.

Function
REQ-018 FSM states SHALL be IDLE, START, FEED, WAIT_DONE, NEXT, FINISH; all outputs SHALL decode from registered state/counters (Moore).
REQ-019 IDLE: go_i with n_steps_i!=0 SHALL latch n_steps_i, clear step_idx_o and err_o, and go to START next cycle.
REQ-020 IDLE: go_i with n_steps_i==0 SHALL pulse done_o and set irq_o one cycle later, staying in IDLE.
REQ-021 go_i outside IDLE SHALL be ignored.
REQ-022 START: core_start_o SHALL be high for exactly this one cycle; beat counter clears; next state FEED.
REQ-023 FEED: core_sample_o SHALL be high every cycle; a beat transfers when core_sample_o && core_ready_i.
REQ-024 FEED: after transfer number N_BEATS, the FSM SHALL go to WAIT_DONE; core_ready_i low stalls it indefinitely without a timeout.
REQ-025 WAIT_DONE: the timeout counter SHALL clear on entry.
REQ-026 WAIT_DONE: core_done_i SHALL move the FSM to NEXT.
REQ-027 WAIT_DONE: if TIMEOUT_CYC cycles elapse without core_done_i, the block SHALL set err_o=1, set irq_o, and return to IDLE; no done_o.
REQ-028 core_done_i and timeout on the same cycle SHALL resolve as done.
REQ-029 NEXT: if step_idx_o == latched n_steps-1, the FSM SHALL go to FINISH; otherwise it increments step_idx_o and goes to START.
REQ-030 Step counter SHALL never wrap; the maximum run is 2^STEP_W-1 steps.
REQ-031 FINISH: done_o SHALL pulse one cycle and irq_o SHALL set; next state IDLE; step_idx_o holds the last index.
REQ-032 abort_i in any non-IDLE state SHALL force IDLE next cycle, set err_o=2, and set irq_o; abort has priority over all other transitions.
REQ-033 abort_i in IDLE SHALL be ignored.
REQ-034 busy_o SHALL equal (state != IDLE).
REQ-035 irq_clr_i SHALL clear irq_o; a set and a clear in the same cycle SHALL leave irq_o set.
REQ-036 Run latency: 1 + sum over steps of (1 + N_BEATS beat cycles + done wait + 1) + 1 cycles from go_i to done_o; with core_ready_i=1 and done 1 cycle after WAIT_DONE entry, each step takes N_BEATS+3 cycles.

Reset
REQ-037 On rst_ni low, the block SHALL asynchronously force state=IDLE, all counters to 0, and core_start_o=0, core_sample_o=0, busy_o=0, done_o=0, irq_o=0, err_o=0, step_idx_o=0.
REQ-038 Reset mid-run SHALL abandon the run silently, with no done_o and no irq_o.

Structure
REQ-039 Package spiker_seq_pkg SHALL hold state_t, the err_o code enum, and the default constants N_BEATS, STEP_W and TIMEOUT_CYC.
REQ-040 Sub-module spiker_seq_wdog SHALL implement the timeout counter with clear, enable and expired ports; everything else stays in spiker_sequencer.

Verification
REQ-041 Single step: n_steps=1, ready=1, done 1 cycle after WAIT_DONE -> one core_start pulse, exactly 200 beats, done_o and irq_o at cycle 204 after go.
REQ-042 Backpressure: n_steps=2, core_ready_i toggling 50% -> exactly 400 accepted beats, step_idx 0 then 1, no timeout.
REQ-043 Timeout: TIMEOUT_CYC=16, core_done_i never -> err_o=1 and irq_o 16 cycles after WAIT_DONE entry, no done_o, busy_o=0.
REQ-044 Abort: abort_i during FEED of step 3 of 5 -> IDLE next cycle, err_o=2, irq_o=1, no further core_start_o.
REQ-045 Edge: go with n_steps=0 -> done_o pulse, no core_start_o; go while busy -> ignored.
REQ-046 Edge: irq_clr_i coincident with FINISH -> irq_o=1.
REQ-047 Edge: rst_ni low mid-WAIT_DONE -> all outputs 0 immediately.
